// File: rtl/gate_bist.sv
// gate_bist: built-in self test for a single combinational logic gate.
// Walks every input vector 0 .. 2**N_IN-1 into the gate under test and holds
// each one for SETTLE cycles. It then compares the gate output against the
// selected reference function for one cycle and accumulates a mismatch count
// and a per-vector failure map.
// Optional feature: define GATE_BIST_TRACE_EN to print one line per check and
// a result line at the end of each run. Without it, no display code is compiled.
module gate_bist #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           gate_sel,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_cnt,
    output logic [2**N_IN-1:0]   fail_map
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [N_IN-1:0] r_vec;
    logic [1:0]      r_sel;
    logic [3:0]      r_settle;

    logic            w_expected;
    logic            w_mismatch;
    logic            w_last_vec;
    logic [N_IN:0]   w_err_next;

    // Reference output for the current vector, using the function latched at start
    always_comb begin
        w_expected = 1'b0;
        case (r_sel)
            2'b00:   w_expected = ~(&r_vec);
            2'b01:   w_expected = ~(|r_vec);
            2'b10:   w_expected = ~r_vec[0];
            default: w_expected = &r_vec;
        endcase
    end

    // Mismatch detection and the count it would produce.
    // The count cannot overflow: at most 2**N_IN mismatches fit in N_IN+1 bits.
    always_comb begin
        w_mismatch = (dut_out != w_expected);
        w_last_vec = &r_vec;
        w_err_next = err_cnt + (N_IN + 1)'(w_mismatch);
    end

    // Sequencer: IDLE -> (APPLY x SETTLE, CHECK) per vector -> DONE -> IDLE.
    // All outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_vec    <= '0;
            r_sel    <= 2'b00;
            r_settle <= 4'd0;
            dut_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_map <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel    <= gate_sel;
                        r_vec    <= '0;
                        r_settle <= 4'd0;
                        dut_in   <= '0;
                        err_cnt  <= '0;
                        fail_map <= '0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (r_settle == 4'(SETTLE - 1)) begin
                        r_settle <= 4'd0;
                        r_state  <= S_CHECK;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                S_CHECK: begin
                    err_cnt <= w_err_next;
                    if (w_mismatch) begin
                        fail_map[r_vec] <= 1'b1;
                    end
`ifdef GATE_BIST_TRACE_EN
                    $display("%0t gate_bist: sel=%b vec=%0d dut_out=%b exp=%b %s",
                             $time, r_sel, r_vec, dut_out, w_expected,
                             w_mismatch ? "MISMATCH" : "MATCH");
`endif
                    if (w_last_vec) begin
                        // Final vector: the result must already include this check
                        r_vec   <= '0;
                        dut_in  <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + N_IN'(1);
                        dut_in  <= r_vec + N_IN'(1);
                        r_state <= S_APPLY;
                    end
                end
                S_DONE: begin
`ifdef GATE_BIST_TRACE_EN
                    $display("%0t gate_bist: run complete pass=%b err_cnt=%0d",
                             $time, pass, err_cnt);
`endif
                    // start is deliberately ignored here, which forces one IDLE cycle
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist. It runs two instances side by side: N_IN=2 with
// SETTLE=1, and N_IN=3 with SETTLE=2. A run-position model predicts every
// output on every cycle. A few literal results pin the model to the
// documented scenarios.
module tb_gate_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] gate_sel = 2'b00;

    logic       d2_out, busy2, done2, pass2;
    logic [1:0] d2_in;
    logic [2:0] err2;
    logic [3:0] fail2;
    logic       d3_out, busy3, done3, pass3;
    logic [2:0] d3_in;
    logic [3:0] err3;
    logic [7:0] fail3;

    int checks = 0;
    int errors = 0;

    // Gate under test, per instance: kind 0 NAND, 1 NOR, 2 NOT, 3 AND.
    // Fault mode 0 correct, 1 stuck-1, 2 random truth table, 3 stuck-0.
    int         kind [2];
    int         fm   [2];
    logic [7:0] lut  [2];

    // Model state per instance: k = -1 idle, 0..L-1 busy cycle index, L = done cycle
    int m_k [2];
    int m_sel [2];
    int m_err [2];
    int m_fail [2];
    int m_pass [2];

    gate_bist #(.N_IN(2), .SETTLE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel),
        .dut_out(d2_out), .dut_in(d2_in), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(err2), .fail_map(fail2)
    );

    gate_bist #(.N_IN(3), .SETTLE(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel),
        .dut_out(d3_out), .dut_in(d3_in), .busy(busy3), .done(done3),
        .pass(pass3), .err_cnt(err3), .fail_map(fail3)
    );

    function automatic logic gexp(input int kd, input int n, input int v);
        int all_ones;
        all_ones = (1 << n) - 1;
        case (kd)
            0:       return logic'(v != all_ones);
            1:       return logic'(v == 0);
            2:       return logic'((v & 1) == 0);
            default: return logic'(v == all_ones);
        endcase
    endfunction

    function automatic logic gate_out(input int kd, input int f, input logic [7:0] lt,
                                      input int n, input int v);
        case (f)
            0:       return gexp(kd, n, v);
            1:       return 1'b1;
            2:       return lt[v[2:0]];
            default: return 1'b0;
        endcase
    endfunction

    always_comb d2_out = gate_out(kind[0], fm[0], lut[0], 2, int'(d2_in));
    always_comb d3_out = gate_out(kind[1], fm[1], lut[1], 3, int'(d3_in));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset(input int i);
        m_k[i] = -1; m_err[i] = 0; m_fail[i] = 0; m_pass[i] = 0; m_sel[i] = 0;
    endtask

    task automatic mcmp(input int i, input int n, input int s, input int b, input int d,
                        input int din, input int p, input int e, input int f);
        int len, eb;
        len = (1 << n) * (s + 1);
        eb  = (m_k[i] >= 0 && m_k[i] < len) ? 1 : 0;
        chk($sformatf("u%0d_busy", n), b, eb);
        chk($sformatf("u%0d_done", n), d, (m_k[i] == len) ? 1 : 0);
        chk($sformatf("u%0d_dut_in", n), din, eb ? m_k[i] / (s + 1) : 0);
        chk($sformatf("u%0d_pass", n), p, m_pass[i]);
        chk($sformatf("u%0d_err_cnt", n), e, m_err[i]);
        chk($sformatf("u%0d_fail_map", n), f, m_fail[i]);
    endtask

    // Predict what the coming rising edge does, from the inputs now present
    task automatic mstep(input int i, input int n, input int s, input logic dout);
        int len, v;
        len = (1 << n) * (s + 1);
        if (m_k[i] < 0) begin
            if (start) begin
                m_k[i] = 0; m_sel[i] = int'(gate_sel);
                m_err[i] = 0; m_fail[i] = 0; m_pass[i] = 0;
            end
        end else if (m_k[i] < len) begin
            if (m_k[i] % (s + 1) == s) begin
                v = m_k[i] / (s + 1);
                if (dout !== gexp(m_sel[i], n, v)) begin
                    m_err[i]++;
                    m_fail[i] = m_fail[i] | (1 << v);
                end
            end
            m_k[i]++;
            if (m_k[i] == len) m_pass[i] = (m_err[i] == 0) ? 1 : 0;
        end else begin
            m_k[i] = -1;
        end
    endtask

    // Single compare process: check both instances every cycle, then advance the model
    always @(negedge clk) begin
        if (!rst_n) begin
            mreset(0);
            mreset(1);
        end
        mcmp(0, 2, 1, int'(busy2), int'(done2), int'(d2_in), int'(pass2), int'(err2), int'(fail2));
        mcmp(1, 3, 2, int'(busy3), int'(done3), int'(d3_in), int'(pass3), int'(err3), int'(fail3));
        if (rst_n) begin
            mstep(0, 2, 1, d2_out);
            mstep(1, 3, 2, d3_out);
        end
    end

    // Start one run and observe ncyc cycles. Inputs change only just after rising edges.
    task automatic run(input logic [1:0] sel, input int ncyc,
                       output int b2, output int b3, output int dn2, output int dn3);
        b2 = 0; b3 = 0; dn2 = 0; dn3 = 0;
        @(posedge clk); #1;
        start = 1'b1; gate_sel = sel;
        for (int c = 0; c <= ncyc; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                if (busy2) b2++;
                if (busy3) b3++;
                if (done2 && dn2 == 0) dn2 = c;
                if (done3 && dn3 == 0) dn3 = c;
            end
            @(posedge clk); #1;
            if (c == 0) start = 1'b0;
        end
        #1;
    endtask

    task automatic set_gut(input int k0, input int f0, input int k1, input int f1);
        kind[0] = k0; fm[0] = f0; kind[1] = k1; fm[1] = f1;
    endtask

    initial begin
        int b2, b3, dn2, dn3, first_done, second_busy, ndone;
        int hold, rc, gc;
        set_gut(0, 0, 0, 0);
        lut[0] = 8'h00; lut[1] = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", int'(busy2), 0);
        chk("reset_fail_map", int'(fail3), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Correct NAND gate, NAND expected
        run(2'b00, 30, b2, b3, dn2, dn3);
        chk("nand_busy_cycles", b2, 8);
        chk("nand_done_cycle", dn2, 9);
        chk("nand_pass", int'(pass2), 1);
        chk("nand_err_cnt", int'(err2), 0);
        chk("nand_fail_map", int'(fail2), 0);

        // Output stuck at 1: only vector 3 should fail
        set_gut(0, 1, 0, 1);
        run(2'b00, 30, b2, b3, dn2, dn3);
        chk("stuck1_err_cnt", int'(err2), 1);
        chk("stuck1_fail_map", int'(fail2), 4'b1000);
        chk("stuck1_pass", int'(pass2), 0);

        // NAND gate checked as NOR: vectors 1 and 2 disagree
        set_gut(0, 0, 0, 0);
        run(2'b01, 30, b2, b3, dn2, dn3);
        chk("nand_as_nor_err_cnt", int'(err2), 2);
        chk("nand_as_nor_fail_map", int'(fail2), 4'b0110);
        chk("nand_as_nor_pass", int'(pass2), 0);

        // Reset in the fourth busy cycle
        @(posedge clk); #1;
        start = 1'b1; gate_sel = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy2), 0);
        chk("abort_dut_in", int'(d2_in), 0);
        chk("abort_err_cnt", int'(err2), 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done2 || done3) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run(2'b00, 30, b2, b3, dn2, dn3);
        chk("after_abort_busy_cycles", b2, 8);
        chk("after_abort_done_cycle", dn2, 9);
        chk("after_abort_pass", int'(pass2), 1);

        // start held high, gate_sel changed mid-run
        first_done = 0; second_busy = 0;
        @(posedge clk); #1;
        start = 1'b1; gate_sel = 2'b00;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (done2 && first_done == 0) begin
                first_done = c;
                chk("held_first_pass", int'(pass2), 1);
            end
            if (first_done != 0 && c > first_done && busy2 && second_busy == 0) second_busy = c;
            @(posedge clk); #1;
            if (c == 3) gate_sel = 2'b01;
            if (c == 12) start = 1'b0;
        end
        chk("held_first_done", first_done, 9);
        chk("held_rerun_gap", second_busy, 11);
        chk("held_second_err_cnt", int'(err2), 2);

        // N_IN=3, SETTLE=2 with a correct NOR gate checked as NOR
        set_gut(1, 0, 1, 0);
        run(2'b01, 40, b2, b3, dn2, dn3);
        chk("nor3_busy_cycles", b3, 24);
        chk("nor3_pass", int'(pass3), 1);
        chk("nor3_fail_map", int'(fail3), 0);

        // Randomized runs; the compare process checks every cycle
        for (int r = 0; r < 30; r++) begin
            @(posedge clk); #1;
            set_gut(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            lut[0] = 8'($urandom); lut[1] = 8'($urandom);
            gate_sel = 2'($urandom);
            start = 1'b1;
            hold = int'($urandom_range(1, 30));
            rc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            gc = int'($urandom_range(1, 40));
            for (int c = 0; c <= 45; c++) begin
                @(negedge clk);
                @(posedge clk); #1;
                if (c == hold) start = 1'b0;
                if (c == gc) gate_sel = 2'($urandom);
                if (c == rc) rst_n = 1'b0;
                if (c == rc + 1) rst_n = 1'b1;
            end
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter N_IN, default 2, number of gate-under-test inputs; legal range 1..4.
REQ-002 Parameter SETTLE, default 1, cycles each vector is held before sampling; legal range 1..15.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  run request, sampled in IDLE only.
REQ-007 gate_sel  in  2  expected function: 00 NAND, 01 NOR, 10 NOT (uses vector bit 0), 11 AND.
REQ-008 dut_out  in  1  output of gate under test.
REQ-009 dut_in  out  N_IN  stimulus vector to gate under test.
REQ-010 busy  out  1  run in progress.
REQ-011 done  out  1  single-cycle end-of-run pulse.
REQ-012 pass  out  1  last run had zero mismatches.
REQ-013 err_cnt  out  N_IN+1  mismatch count of last run.
REQ-014 fail_map  out  2**N_IN  bit v set when vector v mismatched.

Function
REQ-015 FSM SHALL have states IDLE, APPLY, CHECK, DONE.
REQ-016 IDLE: start=1 at an edge SHALL latch gate_sel, clear err_cnt/fail_map/pass, set vector=0, go to APPLY.
REQ-017 APPLY: dut_in=vector; SHALL stay exactly SETTLE cycles, then go to CHECK.
REQ-018 CHECK (1 cycle): dut_in held; dut_out compared with expected(vector) at exiting edge; mismatch SHALL increment err_cnt and set fail_map[vector].
REQ-019 CHECK exit: vector < 2**N_IN-1 -> vector+1, APPLY; else DONE.
REQ-020 DONE (1 cycle): done=1, busy=0, pass=(err_cnt==0); next state IDLE.
REQ-021 busy SHALL be 1 in APPLY and CHECK only; run length 2**N_IN*(SETTLE+1) busy cycles.
REQ-022 dut_in SHALL be 0 in IDLE and DONE.
REQ-023 Expected: NAND ~&v, NOR ~|v, NOT ~v[0], AND &v; latched gate_sel used throughout run; mid-run gate_sel changes ignored.
REQ-024 start while busy or in DONE SHALL be ignored; start held high SHALL rerun after one IDLE cycle.
REQ-025 err_cnt SHALL not wrap (max 2**N_IN fits N_IN+1 bits).
REQ-026 pass, err_cnt, fail_map SHALL hold until next accepted start.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, vector=0, and all outputs (dut_in, busy, done, pass, err_cnt, fail_map) to 0.
REQ-028 Reset mid-run SHALL abort without done pulse; next start SHALL run normally.

Configuration
REQ-029 Macro GATE_BIST_TRACE_EN defined: each CHECK SHALL $display time, gate_sel, vector, dut_out, expected, and MATCH/MISMATCH; DONE SHALL $display pass and err_cnt.
REQ-030 Macro undefined: no display statements compiled; RTL behaviour identical.

Verification
REQ-031 N_IN=2, SETTLE=1, correct NAND DUT, gate_sel=00, start pulse -> busy 8 cycles, done 9 cycles after start edge, pass=1, err_cnt=0, fail_map=4'b0000.
REQ-032 dut_out stuck at 1, gate_sel=00 -> err_cnt=1, fail_map=4'b1000, pass=0.
REQ-033 NAND DUT, gate_sel=01 -> err_cnt=2, fail_map=4'b0110, pass=0.
REQ-034 rst_n low during 4th busy cycle -> all outputs 0 within same cycle, no done; subsequent start gives REQ-031 result.
REQ-035 start held high, gate_sel toggled mid-run -> second run starts one IDLE cycle after done, first run uses latched gate_sel, start during busy ignored.
REQ-036 N_IN=3, SETTLE=2, correct NOR DUT, gate_sel=01 -> busy 24 cycles, pass=1, fail_map=8'h00.
